// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station array: FU class encodings,
// default field widths and the entry record used by dispatch and the FU ports.
package rs_pkg;

    localparam int RS_FU_W      = 4;
    localparam int RS_PRF_W     = 7;
    localparam int RS_PAYLOAD_W = 170;

    localparam logic [RS_FU_W-1:0] FU_ALU = 4'b0001;
    localparam logic [RS_FU_W-1:0] FU_MUL = 4'b0010;
    localparam logic [RS_FU_W-1:0] FU_MEM = 4'b0100;
    localparam logic [RS_FU_W-1:0] FU_BR  = 4'b1000;

    typedef struct packed {
        logic                    valid;
        logic                    op1_rdy;
        logic                    op2_rdy;
        logic [RS_FU_W-1:0]      fu_type;
        logic [RS_PRF_W-1:0]     op1_prn;
        logic [RS_PRF_W-1:0]     op2_prn;
        logic [RS_PAYLOAD_W-1:0] payload;
    } rs_entry_t;

    function automatic logic fu_accepts(input logic [RS_FU_W-1:0] fu,
                                        input logic [RS_FU_W-1:0] mask);
        return |(fu & mask);
    endfunction

endpackage

// File: rtl/mux_onehot.sv
// AND-OR multiplexer driven by a one-hot (or all-zero) select; all-zero selects zero.
module mux_onehot #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            out = out | (data[i*W +: W] & {W{sel[i]}});
        end
    end

endmodule

// File: rtl/rs_array_param_oldest_pick.sv
// Grants the single oldest candidate: older[i][j]=1 means entry i is older than entry j.
module rs_oldest_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0]        elig,
    input  logic [N-1:0][N-1:0] older,
    input  logic [N-1:0]        excl,
    output logic [N-1:0]        grant
);

    logic [N-1:0] cand;

    always_comb begin
        cand  = elig & ~excl;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            // i wins when no other candidate is older than it
            grant[i] = cand[i] & ~|(cand & ~older[i] & ~(N'(1) << i));
        end
    end

endmodule

// File: rtl/rs_array_param.sv
// Parametrised reservation-station array: packed dispatch, CDB wakeup with dispatch
// bypass, age-matrix oldest-first select across ISSUE_W ports, and full flush.
module rs_array_param
    import rs_pkg::*;
#(
    parameter int N_WAY     = 3,
    parameter int ISSUE_W   = 3,
    parameter int RS_SIZE   = 16,
    parameter int CDB_W     = 3,
    parameter int PRF_WIDTH = 7,
    parameter int FU_TYPES  = 4,
    parameter int PAYLOAD_W = 170,
    parameter logic [ISSUE_W*FU_TYPES-1:0] PORT_FU_MASK =
        {FU_ALU | FU_BR, FU_ALU | FU_MUL, FU_ALU | FU_MEM}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [N_WAY-1:0]               disp_valid,
    output logic                           disp_ready,
    input  logic [N_WAY*PAYLOAD_W-1:0]     disp_payload,
    input  logic [N_WAY*PRF_WIDTH-1:0]     disp_op1_prn,
    input  logic [N_WAY*PRF_WIDTH-1:0]     disp_op2_prn,
    input  logic [N_WAY-1:0]               disp_op1_rdy,
    input  logic [N_WAY-1:0]               disp_op2_rdy,
    input  logic [N_WAY*FU_TYPES-1:0]      disp_fu_type,
    input  logic [CDB_W-1:0]               cdb_valid,
    input  logic [CDB_W*PRF_WIDTH-1:0]     cdb_tag,
    input  logic [ISSUE_W-1:0]             iss_ready,
    output logic [ISSUE_W-1:0]             iss_valid,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload,
    output logic [ISSUE_W*PRF_WIDTH-1:0]   iss_op1_prn,
    output logic [ISSUE_W*PRF_WIDTH-1:0]   iss_op2_prn,
    output logic [$clog2(RS_SIZE+1)-1:0]   free_cnt
);

    localparam int CNT_W = $clog2(RS_SIZE+1);
    localparam int ISS_W = PAYLOAD_W + 2*PRF_WIDTH;

    logic [RS_SIZE-1:0]              valid_q, op1_rdy_q, op2_rdy_q;
    logic [FU_TYPES-1:0]             fu_q      [RS_SIZE];
    logic [PRF_WIDTH-1:0]            op1_prn_q [RS_SIZE];
    logic [PRF_WIDTH-1:0]            op2_prn_q [RS_SIZE];
    logic [PAYLOAD_W-1:0]            payload_q [RS_SIZE];
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q;
    logic [CNT_W-1:0]                free_cnt_q;

    function automatic logic cdb_hit(input logic [PRF_WIDTH-1:0]       tag,
                                     input logic [CDB_W-1:0]           cv,
                                     input logic [CDB_W*PRF_WIDTH-1:0] ct);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            hit = hit | (cv[c] && (ct[c*PRF_WIDTH +: PRF_WIDTH] == tag));
        end
        return hit;
    endfunction

    // Dispatch packing: k-th valid lane takes the k-th lowest free entry.
    logic [RS_SIZE-1:0] lane_slot [N_WAY];
    logic [RS_SIZE-1:0] taken, wr_mask;
    logic [CNT_W-1:0]   disp_cnt, acc_cnt, iss_cnt;
    logic               fire;

    always_comb begin
        taken    = '0;
        disp_cnt = '0;
        for (int l = 0; l < N_WAY; l++) begin
            lane_slot[l] = '0;
            if (disp_valid[l]) begin
                disp_cnt = disp_cnt + CNT_W'(1);
                for (int e = 0; e < RS_SIZE; e++) begin
                    if (!valid_q[e] && !taken[e] && (lane_slot[l] == '0)) begin
                        lane_slot[l][e] = 1'b1;
                        taken[e]        = 1'b1;
                    end
                end
            end
        end
    end

    assign disp_ready = (free_cnt_q >= disp_cnt);
    assign fire       = disp_ready && !flush;
    assign wr_mask    = fire ? taken : '0;
    assign acc_cnt    = fire ? disp_cnt : '0;

    logic [RS_SIZE-1:0]   wr_rdy1, wr_rdy2, younger;
    logic [FU_TYPES-1:0]  wr_fu      [RS_SIZE];
    logic [PRF_WIDTH-1:0] wr_prn1    [RS_SIZE];
    logic [PRF_WIDTH-1:0] wr_prn2    [RS_SIZE];
    logic [PAYLOAD_W-1:0] wr_payload [RS_SIZE];
    logic [RS_SIZE-1:0]   wr_row     [RS_SIZE];

    always_comb begin
        wr_rdy1 = '0;
        wr_rdy2 = '0;
        younger = '0;
        for (int e = 0; e < RS_SIZE; e++) begin
            wr_fu[e]      = '0;
            wr_prn1[e]    = '0;
            wr_prn2[e]    = '0;
            wr_payload[e] = '0;
            wr_row[e]     = '0;
        end
        for (int l = 0; l < N_WAY; l++) begin
            // a new entry is older only than entries written by higher lanes this cycle
            younger = '0;
            for (int m = l + 1; m < N_WAY; m++) younger = younger | lane_slot[m];
            for (int e = 0; e < RS_SIZE; e++) begin
                if (lane_slot[l][e]) begin
                    wr_fu[e]      = disp_fu_type[l*FU_TYPES +: FU_TYPES];
                    wr_prn1[e]    = disp_op1_prn[l*PRF_WIDTH +: PRF_WIDTH];
                    wr_prn2[e]    = disp_op2_prn[l*PRF_WIDTH +: PRF_WIDTH];
                    wr_payload[e] = disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                    wr_rdy1[e]    = disp_op1_rdy[l] |
                                    cdb_hit(disp_op1_prn[l*PRF_WIDTH +: PRF_WIDTH], cdb_valid, cdb_tag);
                    wr_rdy2[e]    = disp_op2_rdy[l] |
                                    cdb_hit(disp_op2_prn[l*PRF_WIDTH +: PRF_WIDTH], cdb_valid, cdb_tag);
                    wr_row[e]     = younger;
                end
            end
        end
    end

    logic [RS_SIZE-1:0]              hit1, hit2, ready_vec;
    logic [ISSUE_W-1:0][RS_SIZE-1:0] port_elig, grant;
    logic [ISSUE_W:0][RS_SIZE-1:0]   excl;
    logic [ISSUE_W-1:0][ISS_W-1:0]   iss_word;
    logic [RS_SIZE*ISS_W-1:0]        iss_flat;

    always_comb begin
        hit1     = '0;
        hit2     = '0;
        iss_flat = '0;
        for (int e = 0; e < RS_SIZE; e++) begin
            hit1[e] = cdb_hit(op1_prn_q[e], cdb_valid, cdb_tag);
            hit2[e] = cdb_hit(op2_prn_q[e], cdb_valid, cdb_tag);
            iss_flat[e*ISS_W +: ISS_W] = {payload_q[e], op1_prn_q[e], op2_prn_q[e]};
        end
    end

    assign ready_vec = valid_q & op1_rdy_q & op2_rdy_q;

    always_comb begin
        port_elig = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int e = 0; e < RS_SIZE; e++) begin
                port_elig[p][e] = ready_vec[e] & iss_ready[p] &
                                  fu_accepts(fu_q[e], PORT_FU_MASK[p*FU_TYPES +: FU_TYPES]);
            end
        end
    end

    assign excl[0] = '0;

    for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
        rs_oldest_pick #(.N(RS_SIZE)) u_pick (
            .elig  (port_elig[p]),
            .older (older_q),
            .excl  (excl[p]),
            .grant (grant[p])
        );

        assign excl[p+1] = excl[p] | grant[p];

        mux_onehot #(.N(RS_SIZE), .W(ISS_W)) u_mux (
            .sel  (grant[p]),
            .data (iss_flat),
            .out  (iss_word[p])
        );

        assign iss_valid[p]                          = |grant[p];
        assign iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = iss_word[p][ISS_W-1 -: PAYLOAD_W];
        assign iss_op1_prn[p*PRF_WIDTH +: PRF_WIDTH] = iss_word[p][2*PRF_WIDTH-1 -: PRF_WIDTH];
        assign iss_op2_prn[p*PRF_WIDTH +: PRF_WIDTH] = iss_word[p][PRF_WIDTH-1:0];
    end

    always_comb begin
        iss_cnt = '0;
        for (int p = 0; p < ISSUE_W; p++) iss_cnt = iss_cnt + CNT_W'(iss_valid[p]);
    end

    // excl[ISSUE_W] is the union of all grants this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            op1_rdy_q  <= '0;
            op2_rdy_q  <= '0;
            older_q    <= '0;
            free_cnt_q <= CNT_W'(RS_SIZE);
        end else if (flush) begin
            valid_q    <= '0;
            free_cnt_q <= CNT_W'(RS_SIZE);
        end else begin
            free_cnt_q <= free_cnt_q - acc_cnt + iss_cnt;
            for (int e = 0; e < RS_SIZE; e++) begin
                if (wr_mask[e]) begin
                    valid_q[e]   <= 1'b1;
                    op1_rdy_q[e] <= wr_rdy1[e];
                    op2_rdy_q[e] <= wr_rdy2[e];
                    older_q[e]   <= wr_row[e];
                end else begin
                    if (excl[ISSUE_W][e]) valid_q[e] <= 1'b0;
                    op1_rdy_q[e] <= op1_rdy_q[e] | hit1[e];
                    op2_rdy_q[e] <= op2_rdy_q[e] | hit2[e];
                    older_q[e]   <= older_q[e] | wr_mask;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < RS_SIZE; e++) begin
            if (wr_mask[e]) begin
                fu_q[e]      <= wr_fu[e];
                op1_prn_q[e] <= wr_prn1[e];
                op2_prn_q[e] <= wr_prn2[e];
                payload_q[e] <= wr_payload[e];
            end
        end
    end

    assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_rs_array_param.sv
// Self-checking bench for rs_array_param: directed vector table, hand-written
// corner sequences, then random traffic against an age-ordered queue model.
module tb_rs_array_param;

    localparam int NW = 3;
    localparam int IW = 3;
    localparam int RS = 16;
    localparam int PW = 170;
    localparam int TW = 7;
    localparam int FW = 4;

    logic              clk, rst, flush;
    logic [NW-1:0]     disp_valid, disp_op1_rdy, disp_op2_rdy;
    logic              disp_ready;
    logic [NW*PW-1:0]  disp_payload;
    logic [NW*TW-1:0]  disp_op1_prn, disp_op2_prn;
    logic [NW*FW-1:0]  disp_fu_type;
    logic [2:0]        cdb_valid;
    logic [3*TW-1:0]   cdb_tag;
    logic [IW-1:0]     iss_ready, iss_valid;
    logic [IW*PW-1:0]  iss_payload;
    logic [IW*TW-1:0]  iss_op1_prn, iss_op2_prn;
    logic [4:0]        free_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [11:0] port_mask = {4'b1001, 4'b0011, 4'b0101};

    rs_array_param dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_op1_prn(disp_op1_prn), .disp_op2_prn(disp_op2_prn),
        .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
        .disp_fu_type(disp_fu_type), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_payload(iss_payload),
        .iss_op1_prn(iss_op1_prn), .iss_op2_prn(iss_op2_prn), .free_cnt(free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_pay(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] mk_pay(input logic [7:0] c, input logic [7:0] l);
        return {10'h2A5, {10{c, l}}};
    endfunction

    task automatic set_disp(input logic [2:0] dv, input logic [11:0] fu,
                            input logic [2:0] r1, input logic [6:0] prn1);
        disp_valid   = dv;
        disp_fu_type = fu;
        disp_op1_rdy = r1;
        disp_op2_rdy = '1;
        for (int l = 0; l < NW; l++) begin
            disp_payload[l*PW +: PW] = mk_pay(8'(cyc), 8'(l));
            disp_op1_prn[l*TW +: TW] = prn1;
            disp_op2_prn[l*TW +: TW] = 7'(l + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [2:0]  dv;
        logic [11:0] fu;
        logic [2:0]  r1;
        logic [2:0]  ir;
        logic [2:0]  cv;
        logic [2:0]  e_iv;
        logic [4:0]  e_fc;
        logic        e_dr;
        logic [47:0] e_id;
    } vec_t;

    function automatic vec_t mk_vec(input logic [2:0] dv, input logic [11:0] fu, input logic [2:0] r1,
                                    input logic [2:0] ir, input logic [2:0] cv, input logic [2:0] e_iv,
                                    input logic [4:0] e_fc, input logic e_dr, input logic [47:0] e_id);
        vec_t v;
        v.dv = dv; v.fu = fu; v.r1 = r1; v.ir = ir; v.cv = cv;
        v.e_iv = e_iv; v.e_fc = e_fc; v.e_dr = e_dr; v.e_id = e_id;
        return v;
    endfunction

    // Reference model: resident ops held in age order, oldest first.
    typedef struct {
        logic [PW-1:0] pay;
        logic [TW-1:0] p1, p2;
        logic          r1, r2;
        logic [FW-1:0] fu;
    } m_ent_t;

    m_ent_t mq[$];

    function automatic logic m_hit(input logic [TW-1:0] t);
        logic h;
        h = 1'b0;
        for (int c = 0; c < 3; c++) if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) h = 1'b1;
        return h;
    endfunction

    task automatic model_cycle(input int k);
        int     fc_e;
        logic   dr_e;
        bit     used[RS];
        int     pick;
        m_ent_t nq[$];
        m_ent_t ne;
        fc_e = RS - mq.size();
        dr_e = (fc_e >= $countones(disp_valid));
        for (int i = 0; i < RS; i++) used[i] = 1'b0;
        for (int p = 0; p < IW; p++) begin
            pick = -1;
            if (iss_ready[p]) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (pick < 0 && !used[i] && mq[i].r1 && mq[i].r2 &&
                        (mq[i].fu & port_mask[p*FW +: FW]) != 0) begin
                        pick    = i;
                        used[i] = 1'b1;
                    end
                end
            end
            check($sformatf("rnd%0d.iv%0d", k, p), 32'(iss_valid[p]), 32'(pick >= 0));
            if (pick >= 0) begin
                check_pay($sformatf("rnd%0d.pay%0d", k, p), iss_payload[p*PW +: PW], mq[pick].pay);
                check($sformatf("rnd%0d.prn%0d", k, p),
                      32'({iss_op1_prn[p*TW +: TW], iss_op2_prn[p*TW +: TW]}),
                      32'({mq[pick].p1, mq[pick].p2}));
            end
        end
        check($sformatf("rnd%0d.fc", k), 32'(free_cnt), 32'(fc_e));
        check($sformatf("rnd%0d.dr", k), 32'(disp_ready), 32'(dr_e));
        if (flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!used[i]) begin
                    ne    = mq[i];
                    ne.r1 = ne.r1 | m_hit(ne.p1);
                    ne.r2 = ne.r2 | m_hit(ne.p2);
                    nq.push_back(ne);
                end
            end
            if (dr_e) begin
                for (int l = 0; l < NW; l++) begin
                    if (disp_valid[l]) begin
                        ne.pay = disp_payload[l*PW +: PW];
                        ne.p1  = disp_op1_prn[l*TW +: TW];
                        ne.p2  = disp_op2_prn[l*TW +: TW];
                        ne.r1  = disp_op1_rdy[l] | m_hit(ne.p1);
                        ne.r2  = disp_op2_rdy[l] | m_hit(ne.p2);
                        ne.fu  = disp_fu_type[l*FW +: FW];
                        nq.push_back(ne);
                    end
                end
            end
            mq = nq;
        end
    endtask

    vec_t tbl[15];

    initial begin
        rst = 1'b1; flush = 1'b0; iss_ready = '0; cdb_valid = '0; cdb_tag = '0;
        set_disp(3'b000, 12'h111, 3'b111, 7'd9);

        tbl[0]  = mk_vec(3'b111, 12'h111, 3'b111, 3'b111, 3'b000, 3'b000, 5'd16, 1'b1, 48'h0);
        tbl[1]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b111, 3'b000, 3'b111, 5'd13, 1'b1, 48'h0002_0001_0000);
        tbl[2]  = mk_vec(3'b011, 12'h111, 3'b111, 3'b001, 3'b000, 3'b000, 5'd16, 1'b1, 48'h0);
        tbl[3]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b001, 3'b000, 3'b001, 5'd14, 1'b1, 48'h0000_0000_0200);
        tbl[4]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b001, 3'b000, 3'b001, 5'd15, 1'b1, 48'h0000_0000_0201);
        tbl[5]  = mk_vec(3'b011, 12'h124, 3'b111, 3'b000, 3'b000, 3'b000, 5'd16, 1'b1, 48'h0);
        tbl[6]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b010, 3'b000, 3'b010, 5'd14, 1'b1, 48'h0000_0501_0000);
        tbl[7]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b010, 3'b000, 3'b000, 5'd15, 1'b1, 48'h0);
        tbl[8]  = mk_vec(3'b000, 12'h111, 3'b111, 3'b001, 3'b000, 3'b001, 5'd15, 1'b1, 48'h0000_0000_0500);
        tbl[9]  = mk_vec(3'b001, 12'h111, 3'b000, 3'b111, 3'b000, 3'b000, 5'd16, 1'b1, 48'h0);
        tbl[10] = mk_vec(3'b000, 12'h111, 3'b000, 3'b111, 3'b001, 3'b000, 5'd15, 1'b1, 48'h0);
        tbl[11] = mk_vec(3'b000, 12'h111, 3'b000, 3'b111, 3'b000, 3'b001, 5'd15, 1'b1, 48'h0000_0000_0900);
        tbl[12] = mk_vec(3'b001, 12'h111, 3'b000, 3'b111, 3'b001, 3'b000, 5'd16, 1'b1, 48'h0);
        tbl[13] = mk_vec(3'b000, 12'h111, 3'b000, 3'b111, 3'b000, 3'b001, 5'd15, 1'b1, 48'h0000_0000_0c00);
        tbl[14] = mk_vec(3'b000, 12'h111, 3'b000, 3'b111, 3'b000, 3'b000, 5'd16, 1'b1, 48'h0);

        #12;
        check("reset.iv", 32'(iss_valid), 32'h0);
        check("reset.fc", 32'(free_cnt), 32'd16);
        check("reset.dr", 32'(disp_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        cyc = 0;
        for (int i = 0; i < 15; i++) begin
            set_disp(tbl[i].dv, tbl[i].fu, tbl[i].r1, 7'd9);
            iss_ready = tbl[i].ir;
            cdb_valid = tbl[i].cv;
            cdb_tag   = {7'd0, 7'd0, 7'd9};
            #1;
            check($sformatf("t%0d.iv", i), 32'(iss_valid), 32'(tbl[i].e_iv));
            check($sformatf("t%0d.fc", i), 32'(free_cnt), 32'(tbl[i].e_fc));
            check($sformatf("t%0d.dr", i), 32'(disp_ready), 32'(tbl[i].e_dr));
            for (int p = 0; p < IW; p++) begin
                if (tbl[i].e_iv[p])
                    check($sformatf("t%0d.id%0d", i, p), 32'(iss_payload[p*PW +: 16]),
                          32'(tbl[i].e_id[p*16 +: 16]));
            end
            tick();
        end

        // fill to 15 with unready ops, then all-or-nothing acceptance at the boundary
        cdb_valid = '0;
        iss_ready = 3'b111;
        for (int k = 0; k < 5; k++) begin
            set_disp(3'b111, 12'h111, 3'b000, 7'd9);
            #1;
            check($sformatf("fill%0d.dr", k), 32'(disp_ready), 32'h1);
            tick();
        end
        set_disp(3'b011, 12'h111, 3'b111, 7'd9);
        #1;
        check("full.fc15", 32'(free_cnt), 32'd1);
        check("full.dr_two", 32'(disp_ready), 32'h0);
        tick();
        set_disp(3'b000, 12'h111, 3'b111, 7'd9);
        #1;
        check("full.fc_kept", 32'(free_cnt), 32'd1);
        check("full.no_iss", 32'(iss_valid), 32'h0);
        set_disp(3'b001, 12'h111, 3'b111, 7'd20);
        #1;
        check("full.dr_one", 32'(disp_ready), 32'h1);
        tick();
        set_disp(3'b001, 12'h111, 3'b111, 7'd9);
        #1;
        check("full.fc0", 32'(free_cnt), 32'd0);
        check("full.dr_none", 32'(disp_ready), 32'h0);
        // only the last op is ready; with the array full it still issues
        check("full.last_iss", 32'(iss_valid), 32'b001);
        set_disp(3'b000, 12'h111, 3'b111, 7'd9);
        #1;
        check("full.dr_idle", 32'(disp_ready), 32'h1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush.fc", 32'(free_cnt), 32'd16);
        flush = 1'b1;
        set_disp(3'b111, 12'h111, 3'b111, 7'd9);
        tick();
        flush = 1'b0;
        set_disp(3'b000, 12'h111, 3'b111, 7'd9);
        #1;
        check("flush_disp.fc", 32'(free_cnt), 32'd16);
        check("flush_disp.iv", 32'(iss_valid), 32'h0);

        // async reset mid-cycle with five resident ready ops
        iss_ready = 3'b000;
        set_disp(3'b111, 12'h111, 3'b111, 7'd9);
        tick();
        set_disp(3'b011, 12'h111, 3'b111, 7'd9);
        tick();
        set_disp(3'b000, 12'h111, 3'b111, 7'd9);
        iss_ready = 3'b111;
        #1;
        check("arst.pre_fc", 32'(free_cnt), 32'd11);
        check("arst.pre_iv", 32'(iss_valid), 32'b111);
        #2;
        rst = 1'b1;
        #1;
        check("arst.iv", 32'(iss_valid), 32'h0);
        check("arst.fc", 32'(free_cnt), 32'd16);
        set_disp(3'b111, 12'h111, 3'b111, 7'd9);
        #1;
        check("arst.dr", 32'(disp_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();

        for (int k = 0; k < 400; k++) begin
            disp_valid = 3'($urandom_range(0, 7));
            for (int l = 0; l < NW; l++) begin
                disp_payload[l*PW +: PW] = mk_pay(8'(cyc), 8'($urandom_range(0, 255)));
                disp_op1_prn[l*TW +: TW] = 7'($urandom_range(0, 7));
                disp_op2_prn[l*TW +: TW] = 7'($urandom_range(0, 7));
                disp_fu_type[l*FW +: FW] = 4'(1 << $urandom_range(0, 3));
                cdb_tag[l*TW +: TW]      = 7'($urandom_range(0, 7));
            end
            disp_op1_rdy = 3'($urandom_range(0, 7));
            disp_op2_rdy = 3'($urandom_range(0, 7));
            cdb_valid    = 3'($urandom_range(0, 7));
            iss_ready    = 3'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 39) == 0);
            #1;
            model_cycle(k);
            tick();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
